// File: rtl/rtr_lar_route_stage.sv
// Lookahead routing stage: computes {port, rc} for the next router on head flits, holds it for
// the rest of the packet, and registers each flit in a one-deep valid/ready pipeline slot.
module rtr_lar_route_stage #(
    parameter int unsigned num_resource_classes = 2,
    parameter int unsigned num_routers_per_dim  = 4,
    parameter int unsigned num_dimensions       = 2,
    parameter int unsigned num_nodes_per_router = 1,
    parameter int unsigned flit_data_width      = 64,
    localparam int unsigned dim_addr_width      = $clog2(num_routers_per_dim),
    localparam int unsigned router_addr_width   = num_dimensions * dim_addr_width,
    localparam int unsigned node_addr_width     = $clog2(num_nodes_per_router),
    localparam int unsigned dest_info_width     =
        num_resource_classes * router_addr_width + node_addr_width,
    localparam int unsigned num_ports           = 2 * num_dimensions + num_nodes_per_router,
    localparam int unsigned port_idx_width      = $clog2(num_ports),
    localparam int unsigned resource_class_idx_width = $clog2(num_resource_classes),
    localparam int unsigned lar_info_width      = port_idx_width + resource_class_idx_width
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                in_head,
    input  logic                                in_tail,
    input  logic [resource_class_idx_width-1:0] in_rc,
    input  logic [router_addr_width-1:0]        in_next_router_address,
    input  logic [dest_info_width-1:0]          in_dest_info,
    input  logic [flit_data_width-1:0]          in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_head,
    output logic                                out_tail,
    output logic [lar_info_width-1:0]           out_lar_info,
    output logic [flit_data_width-1:0]          out_data,
    output logic                                error
);

    typedef enum logic [0:0] {StIdle, StInPkt} state_e;

    state_e                          state_q;
    logic                            out_valid_q, out_head_q, out_tail_q, error_q;
    logic [lar_info_width-1:0]       out_lar_q, lar_q;
    logic [flit_data_width-1:0]      out_data_q;

    logic                            in_accept;
    logic [router_addr_width-1:0]    dest_c;
    logic [router_addr_width-1:0]    sel_dest;
    logic [resource_class_idx_width-1:0] sel_rc, route_rc;
    logic                            found_c, found_d;
    logic [port_idx_width-1:0]       node_port, route_port;
    logic [lar_info_width-1:0]       route_lar;

    assign in_ready  = !out_valid_q || out_ready;
    assign in_accept = in_valid && in_ready;

    // Node address field sits above all per-class router addresses.
    if (node_addr_width > 0) begin : g_node
        assign node_port = port_idx_width'(2 * num_dimensions) +
            port_idx_width'(in_dest_info[dest_info_width-1 -: node_addr_width]);
    end else begin : g_no_node
        assign node_port = port_idx_width'(2 * num_dimensions);
    end

    always_comb begin
        dest_c   = '0;
        sel_dest = '0;
        sel_rc   = '0;
        found_c  = 1'b0;
        for (int unsigned c = 0; c < num_resource_classes; c++) begin
            dest_c = in_dest_info[c*router_addr_width +: router_addr_width];
            if (!found_c && c >= 32'(in_rc) && dest_c != in_next_router_address) begin
                found_c  = 1'b1;
                sel_rc   = resource_class_idx_width'(c);
                sel_dest = dest_c;
            end
        end

        found_d    = 1'b0;
        route_port = node_port;
        route_rc   = resource_class_idx_width'(num_resource_classes - 1);
        if (found_c) begin
            route_rc = sel_rc;
            for (int unsigned d = 0; d < num_dimensions; d++) begin
                if (!found_d && in_next_router_address[d*dim_addr_width +: dim_addr_width] !=
                                sel_dest[d*dim_addr_width +: dim_addr_width]) begin
                    found_d    = 1'b1;
                    route_port = (sel_dest[d*dim_addr_width +: dim_addr_width] <
                                  in_next_router_address[d*dim_addr_width +: dim_addr_width])
                               ? port_idx_width'(2 * d) : port_idx_width'(2 * d + 1);
                end
            end
        end
        route_lar = {route_port, route_rc};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_head_q  <= 1'b0;
            out_tail_q  <= 1'b0;
            out_lar_q   <= '0;
            out_data_q  <= '0;
            lar_q       <= '0;
            error_q     <= 1'b0;
        end else if (in_accept) begin
            out_valid_q <= 1'b1;
            out_head_q  <= in_head;
            out_tail_q  <= in_tail;
            out_data_q  <= in_data;
            out_lar_q   <= in_head ? route_lar : lar_q;
            if (in_head) begin
                lar_q   <= route_lar;
                state_q <= in_tail ? StIdle : StInPkt;
            end else if (in_tail) begin
                state_q <= StIdle;
            end
            // Head inside a packet, or body/tail with no open packet.
            if (in_head == (state_q == StInPkt)) begin
                error_q <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_head     = out_head_q;
    assign out_tail     = out_tail_q;
    assign out_lar_info = out_lar_q;
    assign out_data     = out_data_q;
    assign error        = error_q;

endmodule

// File: tb/tb_rtr_lar_route_stage.sv
// Directed bench for rtr_lar_route_stage with default parameters (4-bit router address,
// 8-bit dest info {D1, D0}, lar = {3-bit port, 1-bit rc}).
module tb_rtr_lar_route_stage;

    logic        clk, reset;
    logic        in_valid, in_ready, in_head, in_tail;
    logic [0:0]  in_rc;
    logic [3:0]  in_next_router_address;
    logic [7:0]  in_dest_info;
    logic [63:0] in_data;
    logic        out_valid, out_ready, out_head, out_tail, error;
    logic [3:0]  out_lar_info;
    logic [63:0] out_data;

    int checks   = 0;
    int failures = 0;

    rtr_lar_route_stage dut (
        .clk                    (clk),
        .reset                  (reset),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .in_head                (in_head),
        .in_tail                (in_tail),
        .in_rc                  (in_rc),
        .in_next_router_address (in_next_router_address),
        .in_dest_info           (in_dest_info),
        .in_data                (in_data),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .out_head               (out_head),
        .out_tail               (out_tail),
        .out_lar_info           (out_lar_info),
        .out_data               (out_data),
        .error                  (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Address encoding: {dim1, dim0}, e.g. (1,1) = 4'h5, (3,1) = 4'h7, (2,1) = 4'h6.
    logic [0:0]  rt_rc   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0]  rt_addr [4] = '{4'h5, 4'h6, 4'h6, 4'h5};
    logic [7:0]  rt_dest [4] = '{8'h07, 8'h26, 8'h66, 8'h47};
    logic [3:0]  rt_lar  [4] = '{4'h2, 4'h5, 4'h9, 4'h1};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic h, input logic t, input logic [0:0] rc,
                         input logic [3:0] a, input logic [7:0] di, input logic [63:0] d);
        in_valid = 1'b1;
        in_head = h;
        in_tail = t;
        in_rc = rc;
        in_next_router_address = a;
        in_dest_info = di;
        in_data = d;
    endtask

    task automatic pulse_reset;
        #1 reset = 1'b0;
        #1 reset = 1'b1;
    endtask

    task automatic test_reset;
        logic [70:0] got;
        #12;
        got = {out_valid, out_head, out_tail, out_lar_info, out_data};
        checks++;
        if (got !== 71'd0 || error !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got %h err %b exp 0 err 0", got, error);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_route;
        logic [70:0] got, exp;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, rt_rc[i], rt_addr[i], rt_dest[i], 64'h1000 + 64'(i));
            tick();
            got = {out_valid, out_head, out_tail, out_lar_info, out_data};
            exp = {1'b1, 1'b1, 1'b1, rt_lar[i], 64'h1000 + 64'(i)};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL route_%0d got %h exp %h", i, got, exp);
            end
            in_valid = 1'b0;
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL route_drain_%0d out_valid got %b exp 0", i, out_valid);
            end
        end
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL route_no_error got %b exp 0", error);
        end
    endtask

    task automatic test_stall;
        logic [70:0] got, exp;
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 4'h5, 8'h07, 64'hA0);
        tick();
        got = {out_valid, out_head, out_tail, out_lar_info, out_data};
        exp = {1'b1, 1'b1, 1'b0, 4'h2, 64'hA0};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL stall_head got %h exp %h", got, exp);
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 64'hA1);
        tick();
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 64'hA2);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_in_ready_%0d got %b exp 0", i, in_ready);
            end
            tick();
            got = {out_valid, out_head, out_tail, out_lar_info, out_data};
            exp = {1'b1, 1'b0, 1'b0, 4'h2, 64'hA1};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL stall_hold_%0d got %h exp %h", i, got, exp);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release_ready got %b exp 1", in_ready);
        end
        tick();
        got = {out_valid, out_head, out_tail, out_lar_info, out_data};
        exp = {1'b1, 1'b0, 1'b0, 4'h2, 64'hA2};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL stall_body2 got %h exp %h", got, exp);
        end
        drive(1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 64'hA3);
        tick();
        got = {out_valid, out_head, out_tail, out_lar_info, out_data};
        exp = {1'b1, 1'b0, 1'b1, 4'h2, 64'hA3};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL stall_tail got %h exp %h", got, exp);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL stall_drain valid %b err %b exp 0 0", out_valid, error);
        end
    endtask

    task automatic test_errors;
        logic [70:0] got, exp;
        pulse_reset();
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 64'hB0);
        tick();
        got = {out_valid, out_head, out_tail, out_lar_info, out_data};
        exp = {1'b1, 1'b0, 1'b0, 4'h0, 64'hB0};
        checks++;
        if (got !== exp || error !== 1'b1) begin
            failures++;
            $display("FAIL err_orphan_body got %h err %b exp %h err 1", got, error, exp);
        end
        in_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (error !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got %b exp 1", error);
        end
        pulse_reset();
        drive(1'b1, 1'b0, 1'b0, 4'h5, 8'h07, 64'hC0);
        tick();
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL err_clean_head got %b exp 0", error);
        end
        drive(1'b1, 1'b0, 1'b0, 4'h6, 8'h26, 64'hC1);
        tick();
        got = {out_valid, out_head, out_tail, out_lar_info, out_data};
        exp = {1'b1, 1'b1, 1'b0, 4'h5, 64'hC1};
        checks++;
        if (got !== exp || error !== 1'b1) begin
            failures++;
            $display("FAIL err_head_in_pkt got %h err %b exp %h err 1", got, error, exp);
        end
        drive(1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 64'hC2);
        tick();
        got = {out_valid, out_head, out_tail, out_lar_info, out_data};
        exp = {1'b1, 1'b0, 1'b1, 4'h5, 64'hC2};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL err_new_lar_tail got %h exp %h", got, exp);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [70:0] got, exp;
        pulse_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 4'h5, 8'h07, 64'hD0 + 64'(i));
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready_%0d got %b exp 1", i, in_ready);
            end
            tick();
            got = {out_valid, out_head, out_tail, out_lar_info, out_data};
            exp = {1'b1, 1'b1, 1'b1, 4'h2, 64'hD0 + 64'(i)};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL b2b_out_%0d got %h exp %h", i, got, exp);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain valid %b err %b exp 0 0", out_valid, error);
        end
    endtask

    task automatic test_reset_mid_packet;
        logic [70:0] got, exp;
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 4'h6, 8'h26, 64'hE0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 64'hE1);
        tick();
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_lar_info !== 4'h0) begin
            failures++;
            $display("FAIL rst_mid_drop valid %b lar %h exp 0 0", out_valid, out_lar_info);
        end
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 64'hE2);
        tick();
        got = {out_valid, out_head, out_tail, out_lar_info, out_data};
        exp = {1'b1, 1'b0, 1'b0, 4'h0, 64'hE2};
        checks++;
        if (got !== exp || error !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_body got %h err %b exp %h err 1", got, error, exp);
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        in_head = 1'b0;
        in_tail = 1'b0;
        in_rc = 1'b0;
        in_next_router_address = 4'h0;
        in_dest_info = 8'h00;
        in_data = 64'h0;
        out_ready = 1'b1;
        test_reset();
        test_route();
        test_stall();
        test_errors();
        test_back_to_back();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
